imem_ctrl: RTL
==============

IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, instruction word width.
REQ-002 The block SHALL have parameter ADDR_W, default 12, fetch address width.
REQ-003 The block SHALL have parameter DEPTH, default 16, number of words stored (DEPTH <= 2**ADDR_W).
REQ-004 The block SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port ld_start, input, 1, begin a program load at word 0.
REQ-007 The block SHALL have port ld_valid, input, 1, ld_data valid this cycle.
REQ-008 The block SHALL have port ld_last, input, 1, qualifies ld_valid: final word of the program.
REQ-009 The block SHALL have port ld_data, input, DATA_W, word to write.
REQ-010 The block SHALL have port ld_done, output, 1, one-cycle pulse when a load completes.
REQ-011 The block SHALL have port ld_count, output, ADDR_W+1, number of words written by the last completed load.
REQ-012 The block SHALL have port fetch_req, input, 1, fetch request.
REQ-013 The block SHALL have port fetch_addr, input, ADDR_W, fetch address.
REQ-014 The block SHALL have port fetch_rdy, output, 1, request accepted when fetch_req && fetch_rdy.
REQ-015 The block SHALL have port inst_valid, output, 1, inst_out holds a fetched word.
REQ-016 The block SHALL have port inst_ready, input, 1, consumer takes inst_out when inst_valid && inst_ready.
REQ-017 The block SHALL have port inst_out, output, DATA_W, fetched instruction.
REQ-018 The block SHALL have port addr_err, output, 1, sticky out-of-range fetch flag.
REQ-019 The block SHALL have port par_err, output, 1, sticky parity error flag (see Configuration).

Function
REQ-020 The block SHALL implement FSM states IDLE, LOAD and RUN.
REQ-021 IDLE SHALL go to LOAD on ld_start; RUN SHALL go to LOAD on ld_start; ld_start in LOAD SHALL restart the load pointer at 0.
REQ-022 In LOAD, each ld_valid cycle SHALL write ld_data to mem[ptr] and increment ptr.
REQ-023 LOAD SHALL go to RUN after the write with ld_last=1 or the write to DEPTH-1, whichever occurs first, pulse ld_done for one cycle and set ld_count to the number of words written.
REQ-024 ld_valid SHALL be ignored outside LOAD, and ld_start SHALL take priority over ld_valid in the same cycle.
REQ-025 fetch_rdy SHALL be 1 only in RUN when (!inst_valid || inst_ready).
REQ-026 An accepted fetch SHALL produce inst_valid=1 with mem[fetch_addr] on the next cycle (latency 1).
REQ-027 Back-to-back accepted fetches SHALL sustain one word per cycle while inst_ready=1.
REQ-028 While inst_valid && !inst_ready, inst_out and inst_valid SHALL hold stable.
REQ-029 inst_valid SHALL clear after a consumed word with no new accepted fetch.
REQ-030 A fetch with fetch_addr >= DEPTH SHALL still be accepted, return inst_out = 0 and set addr_err.
REQ-031 addr_err and par_err SHALL clear only on rst or ld_start.
REQ-032 Entry into LOAD SHALL clear inst_valid, discarding any in-flight word.

Reset
REQ-033 On rst, the block SHALL set state=IDLE, ptr=0, ld_count=0, ld_done=0, inst_valid=0, inst_out=0, addr_err=0 and par_err=0; fetch_rdy SHALL be 0.
REQ-034 Memory contents SHALL be left unchanged by rst; rst during LOAD SHALL abort the load without pulsing ld_done.

Configuration
REQ-035 With IMEM_PARITY_EN defined, each word SHALL store an even-parity bit computed at write time and checked on every in-range fetch; a mismatch SHALL set par_err in the cycle inst_valid rises.
REQ-036 Without IMEM_PARITY_EN, no parity storage SHALL exist and par_err SHALL be tied to 0.

Structure
REQ-037 Package imem_pkg SHALL hold the FSM state typedef and the default DATA_W/ADDR_W/DEPTH constants.
REQ-038 Storage SHALL be a sub-module imem_ram (one write port, one registered read port, width DATA_W or DATA_W+1), with FSM and handshake in imem_ctrl.

Verification
REQ-039 The bench SHALL cover load-then-fetch: load 0x0234,0x0381,0x1111 (ld_last on the third word), giving ld_done pulse and ld_count=3; fetches of addr 0,1,2 return 0x0234,0x0381,0x1111 one cycle after acceptance.
REQ-040 The bench SHALL cover full load: 16 words with no ld_last, giving auto transition to RUN after word 15 and ld_count=16.
REQ-041 The bench SHALL cover backpressure: inst_ready=0 for 3 cycles after fetch addr 1, where inst_out holds 0x0381, fetch_rdy=0, and the next word arrives the cycle after ready.
REQ-042 The bench SHALL cover range: fetch addr 0x010 with DEPTH=16, giving inst_out=0 and addr_err=1 until the next ld_start.
REQ-043 The bench SHALL cover reset mid-load: rst after 2 of 5 words, giving state IDLE, no ld_done, ld_count=0, and fetch_rdy=0.
REQ-044 The bench SHALL cover parity with IMEM_PARITY_EN: force-flip a stored bit, then fetch it, giving par_err=1; without the macro, par_err stays 0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM state type and default geometry for the instruction memory controller.
// No latency or backpressure of its own; types and constants only.
package imem_pkg;

  localparam int IMEM_DATA_W = 16;
  localparam int IMEM_ADDR_W = 12;
  localparam int IMEM_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// imem_ram: single write port, registered read port; read data appears 1 cycle after re.
// Array is never reset; only the read register resets, and it holds its value while re is low.
module imem_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: program load FSM plus valid/ready fetch port; fetch latency 1, inst_ready low drops fetch_rdy.
// Defining IMEM_PARITY_EN stores an even-parity bit per word and checks it on every in-range fetch.
module imem_ctrl import imem_pkg::*; #(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_rdy,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_out,
  output logic              addr_err,
  output logic              par_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  state_t state_q, state_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [ADDR_W:0] ld_count_q, ld_count_d;
  logic ld_done_q, ld_done_d;
  logic inst_valid_q, inst_valid_d;
  logic oor_q, oor_d;
  logic addr_err_q, addr_err_d;

  logic ram_we, load_fin, accept, in_range, ram_re;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state; ld_start restarts a load from any state
  always_comb begin
    state_d = state_q;
    if (ld_start) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (load_fin) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    ram_we    = (state_q == LOAD) && ld_valid && !ld_start;
    fetch_rdy = (state_q == RUN) && (!inst_valid_q || inst_ready);
  end

  assign load_fin = ram_we && (ld_last || (ptr_q == LAST_C));
  assign in_range = {1'b0, fetch_addr} < DEPTH_C;
  // A fetch coinciding with ld_start is dropped: the load discards in-flight words anyway.
  assign accept   = fetch_req && fetch_rdy && !ld_start;
  assign ram_re   = accept && in_range;

  always_comb begin
    ptr_d        = ptr_q;
    ld_count_d   = ld_count_q;
    ld_done_d    = 1'b0;
    inst_valid_d = inst_valid_q;
    oor_d        = oor_q;
    addr_err_d   = addr_err_q;
    if (ld_start)    ptr_d = '0;
    else if (ram_we) ptr_d = ptr_q + 1'b1;
    if (load_fin) begin
      ld_done_d  = 1'b1;
      ld_count_d = ptr_q + 1'b1;
    end
    if (ld_start)        inst_valid_d = 1'b0;
    else if (accept)     inst_valid_d = 1'b1;
    else if (inst_ready) inst_valid_d = 1'b0;
    if (accept) oor_d = !in_range;
    if (ld_start)    addr_err_d = 1'b0;
    else if (accept) addr_err_d = addr_err_q || !in_range;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      ld_count_q   <= '0;
      ld_done_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      oor_q        <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      ld_count_q   <= ld_count_d;
      ld_done_q    <= ld_done_d;
      inst_valid_q <= inst_valid_d;
      oor_q        <= oor_d;
      addr_err_q   <= addr_err_d;
    end
  end

`ifdef IMEM_PARITY_EN
  logic chk_q, chk_d, par_err_q, par_err_d, par_bad;

  assign ram_wdata = {^ld_data, ld_data};
  // Read data lands the cycle inst_valid rises, so the check is combined into the flag that cycle.
  assign par_bad   = chk_q && (^ram_rdata);

  always_comb begin
    chk_d     = ram_re;
    par_err_d = ld_start ? 1'b0 : (par_err_q || par_bad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      chk_q     <= chk_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q || par_bad;
`else
  assign ram_wdata = ld_data;
  assign par_err   = 1'b0;
`endif

  imem_ram #(
    .W     (RAM_W),
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ptr_q[IDX_W-1:0]),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (fetch_addr[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

  assign ld_done    = ld_done_q;
  assign ld_count   = ld_count_q;
  assign inst_valid = inst_valid_q;
  assign inst_out   = oor_q ? '0 : ram_rdata[DATA_W-1:0];
  assign addr_err   = addr_err_q;

endmodule
